// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types: frame FSM states, data width, odd-parity helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Odd parity holds when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// CPU-side read/status bundle of the PS/2 receiver FIFO.
// Latency: n/a (wiring only).
// Backpressure: none; reads are ignored while the FIFO is empty.
interface ps2_rx_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  import ps2_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                     rd_en;
  logic                     int_clear;
  logic                     err_clear;
  logic [PS2_DATA_BITS-1:0] rd_data;
  logic                     rd_valid;
  logic [CNT_W-1:0]         fifo_count;
  logic                     irq;
  logic                     parity_err;
  logic                     frame_err;
  logic                     overflow;

  // CPU / bus side
  modport master (
    output rd_en, int_clear, err_clear,
    input  rd_data, rd_valid, fifo_count, irq, parity_err, frame_err, overflow
  );

  // Receiver side
  modport slave (
    input  rd_en, int_clear, err_clear,
    output rd_data, rd_valid, fifo_count, irq, parity_err, frame_err, overflow
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample deglitch for the PS/2 clock line.
// Latency: 2 sync cycles + FILTER_LEN filter cycles; fall strobe one cycle after the filtered edge.
// Backpressure: none (free-running sampler).
module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_fall_stb
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  logic          w_sync;

  assign w_sync = r_sync[1];

  // Bring the raw line into the clock domain; idle-high line resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_raw};
  end

  // Accept a level change only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b1;
    else       r_prev <= r_filt;
  end

  assign o_level    = r_filt;
  assign o_fall_stb = r_prev & ~r_filt;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deglitch, 11-bit framing FSM, timeout abort, FWFT byte FIFO.
// Latency: byte visible on rd_data one cycle after the stop-bit falling edge is filtered.
// Backpressure: full FIFO drops bytes and sets overflow; PS2_RX_HOST_INHIBIT_EN adds ps2_clk_oe inhibit.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int FIFO_DEPTH = 4,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT_US = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_rx_fifo_if.slave bus
`ifdef PS2_RX_HOST_INHIBIT_EN
  ,
  output logic ps2_clk_oe
`endif
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;
  localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam int BW          = $clog2(PS2_DATA_BITS);

  // ---------------- input path ----------------
  logic       w_clk_level;
  logic       w_fall_stb;
  logic [1:0] r_data_sync;
  logic       w_data;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk        (clk),
    .reset      (reset),
    .i_raw      (ps2_clk),
    .o_level    (w_clk_level),
    .o_fall_stb (w_fall_stb)
  );

  // Data only needs metastability protection; it is sampled on filtered clock edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_data_sync <= 2'b11;
    else       r_data_sync <= {r_data_sync[0], ps2_data};
  end

  assign w_data = r_data_sync[1];

  // ---------------- frame FSM ----------------
  ps2_state_t               r_state;
  ps2_state_t               w_state_nxt;
  logic [BW-1:0]            r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_par;
  logic [TW-1:0]            r_to_cnt;
  logic                     w_timeout;
  logic                     w_push;
  logic                     w_set_perr;
  logic                     w_set_ferr;
  logic                     w_par_ok;

  assign w_par_ok  = odd_parity_ok(r_shift, r_par);
  assign w_timeout = (r_state != ST_IDLE) && !w_fall_stb &&
                     (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus push/error strobes; timeout overrides any edge handling.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_set_perr  = 1'b0;
    w_set_ferr  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = ST_IDLE;
      w_set_ferr  = 1'b1;
    end else if (w_fall_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_data) w_state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == BW'(PS2_DATA_BITS - 1)) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (w_data && w_par_ok) begin
            w_push = 1'b1;
          end else begin
            w_set_perr = !w_par_ok;
            w_set_ferr = !w_data;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bit counter, LSB-first shift register and parity capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else if (w_fall_stb) begin
      case (r_state)
        ST_IDLE:   r_bit_cnt <= '0;
        ST_DATA: begin
          r_shift   <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        ST_PARITY: r_par <= w_data;
        default:   ;
      endcase
    end
  end

  // Inter-edge gap counter, only live while a frame is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 r_to_cnt <= '0;
    else if (r_state == ST_IDLE || w_fall_stb) r_to_cnt <= '0;
    else if (!w_timeout)                       r_to_cnt <= r_to_cnt + 1'b1;
  end

  // ---------------- FIFO ----------------
  logic [PS2_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW-1:0]            r_rd_ptr;
  logic [CW-1:0]            r_count;
  logic                     w_full;
  logic                     w_pop;
  logic                     w_do_push;
  logic                     w_drop;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_pop     = bus.rd_en && (r_count != '0);
  // A full FIFO still accepts the byte when the head leaves in the same cycle.
  assign w_do_push = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  // Storage array; contents are qualified by the count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= r_shift;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic r_irq;
  logic r_perr;
  logic r_ferr;
  logic r_ovf;

  // Setting events take priority over the matching clear strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq  <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_do_push)          r_irq  <= 1'b1;
      else if (bus.int_clear) r_irq  <= 1'b0;
      if (w_set_perr)         r_perr <= 1'b1;
      else if (bus.err_clear) r_perr <= 1'b0;
      if (w_set_ferr)         r_ferr <= 1'b1;
      else if (bus.err_clear) r_ferr <= 1'b0;
      if (w_drop)             r_ovf  <= 1'b1;
      else if (bus.err_clear) r_ovf  <= 1'b0;
    end
  end

  assign bus.rd_valid   = (r_count != '0);
  assign bus.rd_data    = bus.rd_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.fifo_count = r_count;
  assign bus.irq        = r_irq;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.overflow   = r_ovf;

`ifdef PS2_RX_HOST_INHIBIT_EN
  logic r_clk_oe;

  // Hold the device off only between frames, so an in-flight frame always completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_clk_oe <= 1'b0;
    else       r_clk_oe <= w_full && (r_state == ST_IDLE);
  end

  assign ps2_clk_oe = r_clk_oe;
`endif

  // The filtered level itself is only consumed through its fall strobe.
  logic w_unused;
  assign w_unused = w_clk_level;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: vector table of single frames plus hand-written
// overflow, glitch, timeout, set-wins and async-reset sequences, with a byte scoreboard.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int HALF  = 50;   // 10 kHz PS/2 clock at a 1 MHz nominal system clock

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;
`ifdef PS2_RX_HOST_INHIBIT_EN
  logic ps2_clk_oe;
`endif

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(
    .CLK_HZ     (1_000_000),
    .FIFO_DEPTH (DEPTH),
    .FILTER_LEN (4),
    .TIMEOUT_US (200)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
`ifdef PS2_RX_HOST_INHIBIT_EN
    ,
    .ps2_clk_oe (ps2_clk_oe)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_b;
    logic       exp_perr;
    logic       exp_ferr;
    logic       exp_push;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    cyc(HALF / 2);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
    if (glitch) begin
      cyc(10);
      ps2_clk = 1'b0;
      cyc(2);
      ps2_clk = 1'b1;
      cyc(HALF / 2 - 12);
    end else begin
      cyc(HALF / 2);
    end
  endtask

  // Sends the first nbits of an 11-bit frame; glitch_bit < 0 means no glitch.
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                            input int glitch_bit, input int nbits);
    logic [10:0] f;
    f = {stop_b, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], (i == glitch_bit));
    if (nbits == 11) begin
      ps2_data = 1'b1;
      cyc(100);
    end
  endtask

  task automatic expect_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
  endtask

  task automatic pop_chk(input string name);
    chk({name, "_vld"}, {31'd0, bus.rd_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_dat: got 0x%0h, required nothing queued", name, bus.rd_data);
    end else begin
      chk({name, "_dat"}, {24'd0, bus.rd_data}, {24'd0, exp_q.pop_front()});
    end
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
    chk({name, "_cnt"}, {29'd0, bus.fifo_count}, exp_q.size());
  endtask

  task automatic pulse_int_clear();
    bus.int_clear = 1'b1;
    cyc(1);
    bus.int_clear = 1'b0;
  endtask

  task automatic pulse_err_clear();
    bus.err_clear = 1'b1;
    cyc(1);
    bus.err_clear = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, required completion in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset         = 1'b1;
    ps2_clk       = 1'b1;
    ps2_data      = 1'b1;
    bus.rd_en     = 1'b0;
    bus.int_clear = 1'b0;
    bus.err_clear = 1'b0;
    cyc(3);

    chk("rst_vld",  {31'd0, bus.rd_valid},   32'd0);
    chk("rst_dat",  {24'd0, bus.rd_data},    32'd0);
    chk("rst_cnt",  {29'd0, bus.fifo_count}, 32'd0);
    chk("rst_irq",  {31'd0, bus.irq},        32'd0);
    chk("rst_perr", {31'd0, bus.parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, bus.frame_err},  32'd0);
    chk("rst_ovf",  {31'd0, bus.overflow},   32'd0);
    reset = 1'b0;
    cyc(10);

    // Single-frame vector table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_b, -1, 11);
      if (vecs[i].exp_push) expect_push(vecs[i].data);
      chk($sformatf("v%0d_perr", i), {31'd0, bus.parity_err}, {31'd0, vecs[i].exp_perr});
      chk($sformatf("v%0d_ferr", i), {31'd0, bus.frame_err},  {31'd0, vecs[i].exp_ferr});
      chk($sformatf("v%0d_irq", i),  {31'd0, bus.irq},        {31'd0, vecs[i].exp_push});
      chk($sformatf("v%0d_cnt", i),  {29'd0, bus.fifo_count}, exp_q.size());
      if (vecs[i].exp_push) begin
        pop_chk($sformatf("v%0d_pop", i));
        pulse_int_clear();
        chk($sformatf("v%0d_irqclr", i), {31'd0, bus.irq}, 32'd0);
      end
      pulse_err_clear();
      chk($sformatf("v%0d_perrclr", i), {31'd0, bus.parity_err}, 32'd0);
      chk($sformatf("v%0d_ferrclr", i), {31'd0, bus.frame_err},  32'd0);
    end

    // Push coinciding with a held int_clear: irq must rise, then clear next cycle
    bus.int_clear = 1'b1;
    fork
      send_frame(8'h33, 1'b0, 1'b1, -1, 11);
      begin
        int k = 0;
        while (!bus.rd_valid && k < 2000) begin
          cyc(1);
          k++;
        end
        chk("irqsw_vld", {31'd0, bus.rd_valid}, 32'd1);
        chk("irqsw_set", {31'd0, bus.irq},      32'd1);
        cyc(1);
        chk("irqsw_clr", {31'd0, bus.irq},      32'd0);
      end
    join
    bus.int_clear = 1'b0;
    expect_push(8'h33);
    pop_chk("irqsw_pop");

    // Parity error coinciding with a held err_clear: flag must still appear
    bus.err_clear = 1'b1;
    fork
      send_frame(8'h44, 1'b1, 1'b1, -1, 11);
      begin
        int k = 0;
        while (!bus.parity_err && k < 2000) begin
          cyc(1);
          k++;
        end
        chk("errsw_set", {31'd0, bus.parity_err}, 32'd1);
      end
    join
    chk("errsw_clr", {31'd0, bus.parity_err}, 32'd0);
    bus.err_clear = 1'b0;

    // Overflow: five frames, no reads
    for (int b = 1; b <= 5; b++) begin
      send_frame(8'(b), 1'b0, 1'b1, -1, 11);
      expect_push(8'(b));
    end
    chk("ovf_cnt",  {29'd0, bus.fifo_count}, 32'd4);
    chk("ovf_flag", {31'd0, bus.overflow},   32'd1);
    chk("ovf_irq",  {31'd0, bus.irq},        32'd1);
    for (int b = 0; b < 4; b++) pop_chk($sformatf("ovf_pop%0d", b));
    chk("ovf_empty", {31'd0, bus.rd_valid}, 32'd0);
    bus.rd_en = 1'b1;
    cyc(1);
    bus.rd_en = 1'b0;
    chk("empty_rd_cnt", {29'd0, bus.fifo_count}, 32'd0);
    pulse_err_clear();
    chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);
    pulse_int_clear();

    // Glitches: idle glitch with data low must not open a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    cyc(2);
    ps2_clk  = 1'b1;
    cyc(20);
    ps2_data = 1'b1;
    cyc(300);
    chk("glitch_idle_ferr", {31'd0, bus.frame_err},  32'd0);
    chk("glitch_idle_cnt",  {29'd0, bus.fifo_count}, 32'd0);
    send_frame(8'hAA, 1'b0, 1'b1, 3, 11);
    expect_push(8'hAA);
    chk("glitch_perr", {31'd0, bus.parity_err}, 32'd0);
    chk("glitch_ferr", {31'd0, bus.frame_err},  32'd0);
    pop_chk("glitch_pop");
    pulse_int_clear();

    // Timeout: start plus four data bits, then silence
    send_frame(8'h0F, 1'b0, 1'b1, -1, 5);
    ps2_data = 1'b1;
    cyc(400);
    chk("to_ferr", {31'd0, bus.frame_err},  32'd1);
    chk("to_cnt",  {29'd0, bus.fifo_count}, 32'd0);
    pulse_err_clear();
    send_frame(8'hF0, 1'b0, 1'b1, -1, 11);
    expect_push(8'hF0);
    chk("to_next_ferr", {31'd0, bus.frame_err}, 32'd0);
    pop_chk("to_next_pop");
    pulse_int_clear();

    // Reset mid-frame with two bytes queued
    send_frame(8'h11, 1'b0, 1'b1, -1, 11);
    expect_push(8'h11);
    send_frame(8'h22, 1'b0, 1'b1, -1, 11);
    expect_push(8'h22);
    chk("mr_cnt_pre", {29'd0, bus.fifo_count}, 32'd2);
    send_frame(8'h77, 1'b0, 1'b1, -1, 6);
    reset = 1'b1;
    #1;
    chk("mr_vld", {31'd0, bus.rd_valid},   32'd0);
    chk("mr_dat", {24'd0, bus.rd_data},    32'd0);
    chk("mr_cnt", {29'd0, bus.fifo_count}, 32'd0);
    chk("mr_irq", {31'd0, bus.irq},        32'd0);
    exp_q.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(20);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 11);
    expect_push(8'h5A);
    chk("mr_next_irq",  {31'd0, bus.irq},        32'd1);
    chk("mr_next_ferr", {31'd0, bus.frame_err},  32'd0);
    pop_chk("mr_next_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard decoder. Synchronises and deglitches ps2_clk/ps2_data, frames 11-bit packets with an explicit FSM, checks start/odd-parity/stop, and recovers from aborted frames by timeout. Good bytes go into a FIFO with first-word-fall-through reads, a sticky interrupt and sticky error flags, so the CPU bus interface can drain scancode bursts without loss.

Parameters:
CLK_HZ, 25_000_000, system clock frequency in Hz
FIFO_DEPTH, 4, FIFO entries; power of 2, minimum 2
FILTER_LEN, 4, consecutive equal synchronised samples needed to accept a ps2_clk level change
TIMEOUT_US, 200, maximum gap between falling edges within one frame before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock
ps2_data  in  1  raw PS/2 data
rd_en  in  1  pop FIFO head; ignored when empty
int_clear  in  1  clears irq
err_clear  in  1  clears parity_err, frame_err, overflow
rd_data  out  8  FIFO head byte, valid when rd_valid=1
rd_valid  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
irq  out  1  sticky: byte pushed since last int_clear
parity_err  out  1  sticky parity failure
frame_err  out  1  sticky bad start/stop or timeout
overflow  out  1  sticky: good byte dropped because FIFO full

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; filtered clock = 1; ps2_clk_prev = 1.
- Input path: 2-flop synchroniser on both lines. Filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronised samples. A falling edge is a filtered 1->0 transition, one-cycle strobe fall_stb.
- FSM (advances only on fall_stb, samples synchronised ps2_data):
  IDLE: data=0 -> DATA, bit_cnt=0. data=1 -> stay in IDLE, no error.
  DATA: shift in LSB first; after 8th bit -> PARITY.
  PARITY: capture parity bit -> STOP.
  STOP: if stop=1 and ^{byte,parity}=1, push byte. Otherwise set parity_err (parity bad) and/or frame_err (stop=0); no push. -> IDLE.
- Timeout: counter runs while FSM != IDLE and resets on each fall_stb. Reaching CLK_HZ/1_000_000*TIMEOUT_US cycles -> IDLE, frame_err=1, partial byte discarded.
- Push happens in the cycle STOP handles fall_stb. rd_valid/rd_data/fifo_count update the next cycle. irq sets the same next cycle.
- FIFO: pop when rd_en && rd_valid. Push while full drops the byte and sets overflow, unless the same cycle pops: then both happen and count is unchanged. Push and pop while not full leave count unchanged. Pointers wrap modulo FIFO_DEPTH.
- irq: set on push, cleared by int_clear. A push in the same cycle as int_clear leaves irq=1. Errors: set wins over err_clear in the same cycle.
- Reset mid-frame aborts the frame and empties the FIFO immediately (asynchronous).

Optional Feature:
PS2_RX_HOST_INHIBIT_EN
- Defined: adds output ps2_clk_oe (1 = drive ps2_clk low). It asserts when fifo_count==FIFO_DEPTH and FSM is IDLE, and deasserts the cycle after count drops. A frame already in progress completes first, so overflow stays reachable only by that in-flight frame.
- Undefined: port absent; a full FIFO drops bytes and sets overflow.

Decomposition:
- Package ps2_pkg: FSM state encoding (IDLE, DATA, PARITY, STOP), PS2_DATA_BITS=8, helper function for odd parity.
- Sub-module ps2_sync_filter: synchroniser plus FILTER_LEN deglitch, outputs filtered level and fall_stb. One instance for ps2_clk; ps2_data is synchronised only.
- FIFO stays inline.

Test Plan:
- Frame 0x1C, parity 0, stop 1 at 10 kHz -> rd_valid=1, rd_data=0x1C, fifo_count=1, irq=1; rd_en pulse -> rd_valid=0; int_clear -> irq=0.
- Frame 0x1C with parity 1 -> parity_err=1, fifo_count=0, irq=0; err_clear -> parity_err=0.
- Five good frames 0x01..0x05, no reads, FIFO_DEPTH=4 -> fifo_count=4, overflow=1; reads return 0x01,0x02,0x03,0x04.
- 2-cycle low glitch on ps2_clk while IDLE and mid-DATA (FILTER_LEN=4) -> no bit shifted; following clean frame 0xAA received intact.
- Start + 4 data bits then ps2_clk held high past TIMEOUT_US -> frame_err=1, FSM IDLE; next frame 0xF0 -> rd_data=0xF0.
- reset asserted after 6 bits with 2 bytes queued -> all outputs 0 immediately; next frame 0x5A received correctly.
